// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says colour display path:
// colour codes, display FSM states, LFSR seed and LFSR step helper.
package simon_pkg;

   localparam logic [1:0] COLOR_0 = 2'd0;
   localparam logic [1:0] COLOR_1 = 2'd1;
   localparam logic [1:0] COLOR_2 = 2'd2;
   localparam logic [1:0] COLOR_3 = 2'd3;

   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } state_e;

   // One Fibonacci step of x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

endpackage

// File: rtl/color_test_if.sv
// Request/colour bundle between the game controller and the colour generator.
interface color_test_if;
   logic       DisplayColors;
   logic [1:0] ColorOut;

   modport master (output DisplayColors, input ColorOut);
   modport slave  (input DisplayColors, output ColorOut);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load; load wins over advance.
module lfsr16
   import simon_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_r;

   assign q = q_r;

   // Shift register state: reset/load take the seed, advance steps once.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= seed;
      end else if (load) begin
         q_r <= seed;
      end else if (advance) begin
         q_r <= lfsr_step(q_r);
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/color_test.sv
// Colour-sequence player: while DisplayColors is high, shows SEQ_LEN colours
// from the LFSR, each for HOLD_CYCLES clocks, then parks at 00 until the
// request drops. The LFSR runs one step ahead of the displayed colour, so
// each new colour is simply the current q[1:0] captured at the step boundary.
module color_test
   import simon_pkg::*;
#(
   parameter int          SEQ_LEN     = 8,
   parameter int          HOLD_CYCLES = 2,
   parameter logic [15:0] SEED        = LFSR_SEED_DEFAULT
)
(
   input  logic       DisplayColors,
   input  logic       clk,
   input  logic       reset,
   output logic [1:0] ColorOut
);

   localparam int         HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [7:0] STEP_LAST = 8'(SEQ_LEN - 1);

   state_e            state_r;
   logic [1:0]        color_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [7:0]        step_cnt_r;

   logic              lfsr_load_s;
   logic              lfsr_adv_s;
   logic [1:0]        lfsr_color_s;
   logic [13:0]       lfsr_hi_unused_s;
   logic              hold_end_s;
   logic              step_more_s;

   assign ColorOut    = color_r;
   assign hold_end_s  = (hold_cnt_r == HOLD_LAST);
   assign step_more_s = (step_cnt_r < STEP_LAST);

   lfsr16 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (lfsr_load_s),
      .advance (lfsr_adv_s),
      .seed    (SEED),
      .q       ({lfsr_hi_unused_s, lfsr_color_s})
   );

   // LFSR control: keep the seed while idle/finished, step on each colour taken.
   always_comb begin
      lfsr_load_s = 1'b0;
      lfsr_adv_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (DisplayColors) begin
               lfsr_adv_s = 1'b1;
            end else begin
               lfsr_load_s = 1'b1;
            end
         end
         SHOW: begin
            if (!DisplayColors) begin
               lfsr_load_s = 1'b1;
            end else if (hold_end_s && step_more_s) begin
               lfsr_adv_s = 1'b1;
            end else begin
               lfsr_adv_s = 1'b0;
            end
         end
         DONE: begin
            if (!DisplayColors) begin
               lfsr_load_s = 1'b1;
            end else begin
               lfsr_load_s = 1'b0;
            end
         end
         default: begin
            lfsr_load_s = 1'b1;
         end
      endcase
   end

   // Playback FSM with registered colour output and hold/step counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         color_r    <= COLOR_0;
         hold_cnt_r <= '0;
         step_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               hold_cnt_r <= '0;
               step_cnt_r <= 8'd0;
               if (DisplayColors) begin
                  state_r <= SHOW;
                  color_r <= lfsr_color_s;
               end else begin
                  color_r <= COLOR_0;
               end
            end
            SHOW: begin
               if (!DisplayColors) begin
                  state_r    <= IDLE;
                  color_r    <= COLOR_0;
                  hold_cnt_r <= '0;
                  step_cnt_r <= 8'd0;
               end else if (hold_end_s) begin
                  hold_cnt_r <= '0;
                  if (step_more_s) begin
                     color_r    <= lfsr_color_s;
                     step_cnt_r <= step_cnt_r + 8'd1;
                  end else begin
                     state_r <= DONE;
                     color_r <= COLOR_0;
                  end
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
            end
            DONE: begin
               color_r <= COLOR_0;
               if (!DisplayColors) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r    <= IDLE;
               color_r    <= COLOR_0;
               hold_cnt_r <= '0;
               step_cnt_r <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_color_test.sv
// Bench for color_test: a hand-computed vector table for the default and the
// 1x1 configuration, then random request/reset traffic checked against a
// timeline model (elapsed cycles since request -> colour index) for three
// parameter sets.
module tb_color_test;
   import simon_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic dc;

   always #5 clk = ~clk;

   color_test_if ifa ();
   color_test_if ifb ();
   color_test_if ifc ();

   assign ifa.DisplayColors = dc;
   assign ifb.DisplayColors = dc;
   assign ifc.DisplayColors = dc;

   color_test dut_a (
      .DisplayColors (ifa.DisplayColors),
      .clk           (clk),
      .reset         (reset),
      .ColorOut      (ifa.ColorOut)
   );

   color_test #(.SEQ_LEN(1), .HOLD_CYCLES(1)) dut_b (
      .DisplayColors (ifb.DisplayColors),
      .clk           (clk),
      .reset         (reset),
      .ColorOut      (ifb.ColorOut)
   );

   color_test #(.SEQ_LEN(5), .HOLD_CYCLES(3)) dut_c (
      .DisplayColors (ifc.DisplayColors),
      .clk           (clk),
      .reset         (reset),
      .ColorOut      (ifc.ColorOut)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   int          m_len  [3] = '{8, 1, 5};
   int          m_hold [3] = '{2, 1, 3};
   int          m_t    [3] = '{-1, -1, -1};  // cycles since playback start, -1 = not playing
   bit          m_done [3] = '{1'b0, 1'b0, 1'b0};
   int unsigned ref_col[$];

   task automatic build_colors();
      int unsigned q;
      int unsigned fb;
      q = 32'hACE1;
      for (int i = 0; i < 16; i++) begin
         ref_col.push_back(q % 4);
         fb = ((q >> 15) ^ (q >> 13) ^ (q >> 12) ^ (q >> 10)) & 1;
         q  = ((q * 2) % 65536) + fb;
      end
   endtask

   task automatic model_edge(input bit r, input bit d);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            m_t[k]    = -1;
            m_done[k] = 1'b0;
         end else if (m_t[k] >= 0) begin
            if (!d) begin
               m_t[k] = -1;
            end else begin
               m_t[k] = m_t[k] + 1;
               if (m_t[k] == m_len[k] * m_hold[k]) begin
                  m_t[k]    = -1;
                  m_done[k] = 1'b1;
               end
            end
         end else if (m_done[k]) begin
            if (!d) m_done[k] = 1'b0;
         end else if (d) begin
            m_t[k] = 0;
         end
      end
   endtask

   function automatic logic [1:0] model_color(input int k);
      if (m_t[k] >= 0) return 2'(ref_col[m_t[k] / m_hold[k]]);
      return 2'd0;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(reset, dc);
      #1;
   endtask

   typedef struct {
      bit         rst;
      bit         d;
      logic [1:0] ea;
      logic [1:0] eb;
   } vec_t;

   vec_t vq[$];

   task automatic add(input bit r, input bit d, input logic [1:0] a, input logic [1:0] b);
      vec_t v;
      v.rst = r; v.d = d; v.ea = a; v.eb = b;
      vq.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      dc    = 1'b0;
      build_colors();

      // Expected default sequence: 01 11 11 11 10 00 01 10, two cycles each.
      add(1'b1, 1'b0, 2'd0, 2'd0);                       // reset
      add(1'b0, 1'b1, 2'd1, 2'd1);                       // first colour after request edge
      add(1'b0, 1'b1, 2'd1, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd2, 2'd0);
      add(1'b0, 1'b1, 2'd2, 2'd0);
      add(1'b0, 1'b1, 2'd0, 2'd0);
      add(1'b0, 1'b1, 2'd0, 2'd0);
      add(1'b0, 1'b1, 2'd1, 2'd0);
      add(1'b0, 1'b1, 2'd1, 2'd0);
      add(1'b0, 1'b1, 2'd2, 2'd0);
      add(1'b0, 1'b1, 2'd2, 2'd0);
      add(1'b0, 1'b1, 2'd0, 2'd0);                       // end of playback
      add(1'b0, 1'b1, 2'd0, 2'd0);                       // held: no replay
      add(1'b0, 1'b1, 2'd0, 2'd0);
      add(1'b0, 1'b0, 2'd0, 2'd0);                       // drop
      add(1'b0, 1'b1, 2'd1, 2'd1);                       // identical restart
      add(1'b0, 1'b1, 2'd1, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);                       // step 3 in progress
      add(1'b0, 1'b0, 2'd0, 2'd0);                       // abort
      add(1'b0, 1'b1, 2'd1, 2'd1);                       // re-request from step 0
      add(1'b0, 1'b1, 2'd1, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);
      add(1'b0, 1'b1, 2'd3, 2'd0);                       // step 2 in progress
      add(1'b1, 1'b1, 2'd0, 2'd0);                       // mid-sequence reset
      add(1'b0, 1'b1, 2'd1, 2'd1);                       // restart after release
      add(1'b0, 1'b1, 2'd1, 2'd0);
      add(1'b0, 1'b0, 2'd0, 2'd0);

      for (int i = 0; i < vq.size(); i++) begin
         reset = vq[i].rst;
         dc    = vq[i].d;
         tick();
         check($sformatf("tbl%0d_a", i), ifa.ColorOut, vq[i].ea);
         check($sformatf("tbl%0d_b", i), ifb.ColorOut, vq[i].eb);
         check($sformatf("tbl%0d_c", i), ifc.ColorOut, model_color(2));
      end

      // Randomised traffic against the timeline model.
      reset = 1'b1;
      dc    = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) check("rnd_reset", (k == 0) ? ifa.ColorOut :
                                                   (k == 1) ? ifb.ColorOut : ifc.ColorOut,
                                        model_color(k));
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 9) == 0) dc = ~dc;
         tick();
         check("rnd_a", ifa.ColorOut, model_color(0));
         check("rnd_b", ifb.ColorOut, model_color(1));
         check("rnd_c", ifc.ColorOut, model_color(2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/color_test.md
# color_test

Color-sequence display generator for the Simon Says game on the Basys3 board. While `DisplayColors` is asserted, the block plays a fixed pseudo-random sequence of 2-bit color codes on `ColorOut`. Each color is held for a programmable number of clock cycles. The block sits between the game controller, which requests playback, and the color/LED decode logic, which consumes `ColorOut`.

## Interface
- `SEQ_LEN`, default 8: number of colors played per request (1..255).
- `HOLD_CYCLES`, default 2: clock cycles each color is held (1..2^24-1).
- `SEED`, default 16'hACE1: LFSR load value; must be nonzero.
- Port order is fixed: `DisplayColors`, `clk`, `reset`, `ColorOut`.
- One clock; reset is synchronous and active-high.
- `clk`, input, 1 bit: single clock, rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `DisplayColors`, input, 1 bit: level request to play the sequence.
- `ColorOut`, output, 2 bits: current color code (00, 01, 10, 11 = four game colors), registered.

## Operation
- FSM with states IDLE, SHOW and DONE. Reset value is IDLE.
- On reset: `ColorOut`=00, LFSR=`SEED`, hold counter=0, step counter=0.
- LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Advance: q <= {q[14:0], q[15]^q[13]^q[12]^q[10]}.
  - Color is always q[1:0].
- IDLE:
  - `ColorOut`=00 and LFSR is held at `SEED`.
  - If `DisplayColors`=1: go to SHOW, drive `ColorOut`=SEED[1:0], clear hold counter, set step counter=0.
- SHOW:
  - The hold counter increments each cycle.
  - When the hold counter reaches `HOLD_CYCLES`-1, the step ends.
    - If step counter < `SEQ_LEN`-1: advance LFSR, drive `ColorOut` with the new q[1:0], increment step, clear hold.
    - Otherwise: go to DONE with `ColorOut`=00.
- DONE:
  - `ColorOut`=00.
  - Stays in DONE while `DisplayColors`=1, so no replay on a held level.
  - Goes to IDLE and reloads `SEED` when `DisplayColors`=0.
- `DisplayColors`=0 in SHOW aborts playback: next cycle IDLE, `ColorOut`=00, LFSR reloaded.
- Every request replays the identical sequence, because the seed is reloaded each time.
- `reset` has priority over all other inputs in every state, including mid-sequence.

## Timing
- Latency: `DisplayColors` sampled high at edge N in IDLE gives the first color valid after edge N.
- Each color is valid for exactly `HOLD_CYCLES` cycles. Colors are contiguous, with no gap cycles.
- Total playback is `SEQ_LEN`*`HOLD_CYCLES` cycles. `ColorOut` returns to 00 on the following edge.
- With `HOLD_CYCLES`=1 the color changes every cycle.
- With `SEQ_LEN`=1 only SEED[1:0] is shown.
- Abort takes effect one edge after `DisplayColors` is sampled low.
- Re-assertion in the cycle directly after an abort starts from step 0.

## Structure
- A shared package `simon_pkg` holds:
  - color constants (COLOR_0..COLOR_3 = 2'd0..2'd3);
  - the state enum (IDLE, SHOW, DONE);
  - `LFSR_SEED_DEFAULT`.
- One sub-module, `lfsr16`, with ports clk, reset, load, advance, seed and q[15:0].
- Counter widths: step counter 8 bits; hold counter sized by $clog2(`HOLD_CYCLES`), minimum 1 bit.

## Test plan
- Reset: hold `reset`=1 across one edge with `DisplayColors`=0 -> `ColorOut`=00, FSM in IDLE.
- Basic playback (defaults):
  - `DisplayColors`=1 from t=10 ns (10 ns clock) -> `ColorOut` = 01, 11, 11, 11, … each for 2 cycles.
  - LFSR goes 0xACE1 -> 0x59C3 -> 0xB387 -> 0x670F.
  - 8 colors total, then 00.
- Held request: keep `DisplayColors`=1 after completion -> `ColorOut` stays 00 with no replay. Drop then raise -> identical sequence restarts at 01.
- Abort: deassert `DisplayColors` during step 3 -> next cycle `ColorOut`=00. Re-request -> sequence restarts at 01.
- Mid-sequence reset: assert `reset` during step 2 with `DisplayColors`=1 -> `ColorOut`=00. After release, restart from step 0 with 01.
- Parameter corner: `HOLD_CYCLES`=1, `SEQ_LEN`=1 -> exactly one cycle of 01, then 00.
